mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
//
// PURPOSE
// - Shares one external memory port between the core's instruction (prefetch) bus and data (load/store) bus.
// - Sits between the core's instr_m_*/data_m_* ports and the system memory.
// - Serialises accesses with fixed data priority and a starvation limit that guarantees prefetch progress.
// - Routes ack and read data back to the granted master only.
//
// PARAMETERS
// - DATA_BURST_MAX  default 4  consecutive data grants allowed while instr is waiting; 1..15.
//
// PORTS
// - clk                input   1   system clock.
// - reset              input   1   synchronous, active-high.
// - instr_m_addr       input   19  prefetch word address [19:1].
// - instr_m_data_in    output  16  read data to prefetch.
// - instr_m_access     input   1   prefetch request.
// - instr_m_ack        output  1   prefetch transfer done.
// - data_m_addr        input   19  load/store word address [19:1].
// - data_m_data_in     output  16  read data to load/store.
// - data_m_data_out    input   16  write data from load/store.
// - data_m_access      input   1   load/store request.
// - data_m_ack         output  1   load/store transfer done.
// - data_m_wr_en       input   1   load/store write strobe.
// - data_m_bytesel     input   2   load/store byte lanes.
// - q_m_addr           output  19  memory word address.
// - q_m_data_in        input   16  memory read data.
// - q_m_data_out       output  16  memory write data.
// - q_m_access         output  1   memory request.
// - q_m_ack            input   1   memory transfer done.
// - q_m_wr_en          output  1   memory write strobe.
// - q_m_bytesel        output  2   memory byte lanes.
//
// BEHAVIOUR
// - States: IDLE, GRANT_DATA, GRANT_INSTR (registered). Reset -> IDLE, burst_cnt=0.
// - IDLE
//   - data_m_access and not starved -> GRANT_DATA.
//   - else instr_m_access -> GRANT_INSTR.
//   - else stay in IDLE.
//   - starved = instr_m_access && burst_cnt == DATA_BURST_MAX.
// - GRANT_x
//   - q_m_access = x_access.
//   - addr, wr_en, bytesel, data_out come from master x. Instr grant: wr_en=0, bytesel=2'b11, data_out=0.
//   - q_m_ack drives x_m_ack combinationally. The other master's ack is 0.
//   - On q_m_ack -> IDLE. This gives one dead cycle between transfers.
//   - If x_access falls without an ack, the transfer is abandoned -> IDLE.
// - IDLE outputs: q_m_access=0, q_m_wr_en=0, q_m_addr=0, q_m_bytesel=0, q_m_data_out=0. Both acks are 0.
// - Reset drives all outputs to these IDLE values.
// - Read data: q_m_data_in is wired to both x_m_data_in. It is valid only with the matching ack.
// - Latency: a request in IDLE is granted the next cycle. Total latency = 1 + memory latency.
// - burst_cnt
//   - On data ack: increments (saturating) if instr_m_access is high, else clears to 0.
//   - Cleared on instr ack.
// - Simultaneous requests in IDLE: data wins unless starved. The next IDLE then grants instr if it is still pending.
// - q_m_ack while in IDLE is ignored and not forwarded.
// - Reset mid-transfer: next cycle is IDLE with q_m_access=0. The in-flight ack is dropped.
// - No combinational path from x_access to grant selection. Grant comes only from state.
//
// STRUCTURE
// - Shared package: ArbState_t enum {ARB_IDLE, ARB_GRANT_DATA, ARB_GRANT_INSTR}; ArbGrant_t {GRANT_NONE, GRANT_DATA, GRANT_INSTR}.
// - Single module containing the FSM, the burst counter and the output mux. No sub-module.
//
// TESTING
// - Instr only: instr_m_access=1 at addr 19'h00100, memory acks 2 cycles later with 16'hBEEF.
//   - Required: q_m_addr=19'h00100, q_m_wr_en=0, q_m_bytesel=2'b11.
//   - Required: instr_m_ack=1 with data BEEF. data_m_ack stays 0.
// - Simultaneous requests: data write at addr 19'h00200, 16'h1234, bytesel 2'b01, alongside an instr request.
//   - Required: data granted first, then 1 IDLE cycle, then instr granted.
// - Starvation: data_m_access held high with instr waiting, DATA_BURST_MAX=4.
//   - Required: exactly 4 data acks, then an instr grant, then data again.
// - Abandon: data granted, data_m_access dropped before ack.
//   - Required: next cycle is IDLE with q_m_access=0. A late q_m_ack is not forwarded.
// - Reset mid-transfer: reset asserted while in GRANT_INSTR.
//   - Required: all outputs at IDLE values the next cycle and burst_cnt=0.
// - Back-to-back data with no instr waiting: burst_cnt stays 0. Every data access is granted with 1 dead cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int BSEL_W = 2;
    localparam int CNT_W  = 4;

    // Registered arbiter state. The grant is derived from this alone.
    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_GRANT_DATA  = 2'd1,
        ARB_GRANT_INSTR = 2'd2
    } ArbState_t;

    // Which master currently owns the memory port.
    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_DATA  = 2'd1,
        GRANT_INSTR = 2'd2
    } ArbGrant_t;

    // Map the state register onto the owner of the memory port.
    function automatic ArbGrant_t grant_of(input ArbState_t state);
        ArbGrant_t grant;
        case (state)
            ARB_GRANT_DATA:  grant = GRANT_DATA;
            ARB_GRANT_INSTR: grant = GRANT_INSTR;
            default:         grant = GRANT_NONE;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one memory port between the prefetch (instr) and the
// load/store (data) masters. Data has fixed priority; a burst counter caps
// how many data grants may pass a waiting prefetch before instr is served.
//
// Handshake: a master holds x_m_access high with stable address/control
// until x_m_ack is seen high for one cycle; that cycle completes the
// transfer and read data on x_m_data_in is valid only in that cycle.
// Dropping x_m_access before the ack abandons the transfer.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    // prefetch master
    input  logic [ADDR_W-1:0] instr_m_addr,
    output logic [DATA_W-1:0] instr_m_data_in,
    input  logic              instr_m_access,
    output logic              instr_m_ack,
    // load/store master
    input  logic [ADDR_W-1:0] data_m_addr,
    output logic [DATA_W-1:0] data_m_data_in,
    input  logic [DATA_W-1:0] data_m_data_out,
    input  logic              data_m_access,
    output logic              data_m_ack,
    input  logic              data_m_wr_en,
    input  logic [BSEL_W-1:0] data_m_bytesel,
    // memory port
    output logic [ADDR_W-1:0] q_m_addr,
    input  logic [DATA_W-1:0] q_m_data_in,
    output logic [DATA_W-1:0] q_m_data_out,
    output logic              q_m_access,
    input  logic              q_m_ack,
    output logic              q_m_wr_en,
    output logic [BSEL_W-1:0] q_m_bytesel,
    // debug visibility of the FSM and burst counter
    output ArbState_t         dbg_state,
    output logic [CNT_W-1:0]  dbg_burst_cnt
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DATA_BURST_MAX);

    ArbState_t        state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    ArbGrant_t        grant;
    logic             starved;

    // Instr has waited through the full allowance of data grants.
    assign starved = instr_m_access && (burst_cnt_q == BURST_MAX);
    assign grant   = grant_of(state_q);

    // Read data goes to both masters; only the acked one may use it.
    assign instr_m_data_in = q_m_data_in;
    assign data_m_data_in  = q_m_data_in;

    assign dbg_state     = state_q;
    assign dbg_burst_cnt = burst_cnt_q;

    // Next-state and burst-counter update.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (data_m_access && !starved) begin
                    state_d = ARB_GRANT_DATA;
                end else if (instr_m_access) begin
                    state_d = ARB_GRANT_INSTR;
                end
            end
            ARB_GRANT_DATA: begin
                if (q_m_ack) begin
                    state_d = ARB_IDLE;
                    // Count only data grants that overtook a waiting prefetch.
                    if (instr_m_access) begin
                        if (burst_cnt_q != BURST_MAX) begin
                            burst_cnt_d = burst_cnt_q + 4'd1;
                        end
                    end else begin
                        burst_cnt_d = '0;
                    end
                end else if (!data_m_access) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT_INSTR: begin
                if (q_m_ack) begin
                    state_d     = ARB_IDLE;
                    burst_cnt_d = '0;
                end else if (!instr_m_access) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output mux: memory port and acks follow the registered grant only.
    always_comb begin
        q_m_access   = 1'b0;
        q_m_addr     = '0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = '0;
        q_m_data_out = '0;
        instr_m_ack  = 1'b0;
        data_m_ack   = 1'b0;
        case (grant)
            GRANT_DATA: begin
                q_m_access   = data_m_access;
                q_m_addr     = data_m_addr;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
                q_m_data_out = data_m_data_out;
                data_m_ack   = q_m_ack;
            end
            GRANT_INSTR: begin
                q_m_access   = instr_m_access;
                q_m_addr     = instr_m_addr;
                q_m_wr_en    = 1'b0;
                q_m_bytesel  = 2'b11;
                q_m_data_out = '0;
                instr_m_ack  = q_m_ack;
            end
            default: begin
                q_m_access = 1'b0;
            end
        endcase
    end

    // State and burst counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule
